dl_frame_tx: RTL

DL_FRAME_TX -- requirements
Module: dl_frame_tx

---
 rtl/dl_frame_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dl_frame_tx.sv
// Serial frame transmitter: alternating preamble, LSB-first payload, and an optional
// silent gap, with repeats, abort and length checking. Every output is registered.
module dl_frame_tx #(
  parameter int DIV_WIDTH     = 8,
  parameter int MAX_BITS      = 128,
  parameter int PREAMBLE_BITS = 16,
  parameter int GAP_WIDTH     = 8,
  parameter int RPT_WIDTH     = 4,
  parameter int LEN_WIDTH     = $clog2(MAX_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [MAX_BITS-1:0]  payload,
  input  logic [LEN_WIDTH-1:0] payload_len,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [GAP_WIDTH-1:0] gap_bits,
  input  logic [RPT_WIDTH-1:0] repeat_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 err_len,
  output logic                 dl_out,
  output logic                 dl_en
);

  // One bit-index counter serves preamble, payload and gap, so it must hold the largest of the three.
  localparam int CNT_A   = (MAX_BITS > PREAMBLE_BITS) ? MAX_BITS : PREAMBLE_BITS;
  localparam int CNT_MAX = (CNT_A > (2**GAP_WIDTH - 1)) ? CNT_A : (2**GAP_WIDTH - 1);
  localparam int IDX_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] timer;
  logic [IDX_W-1:0]     bit_idx;
  logic [MAX_BITS-1:0]  pay_q;
  logic [MAX_BITS-1:0]  sh_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [GAP_WIDTH-1:0] gap_q;
  logic [RPT_WIDTH-1:0] rpt_q;

  logic [IDX_W-1:0] idx_nxt;
  logic             len_ok;
  logic             bit_end;
  logic             frame_end;

  assign idx_nxt   = bit_idx + IDX_W'(1);
  assign len_ok    = (payload_len != '0) && (payload_len <= LEN_WIDTH'(MAX_BITS));
  assign bit_end   = (timer == div_q);
  assign frame_end = bit_end &&
                     (((state == PAYLOAD) && (idx_nxt == IDX_W'(len_q)) && (gap_q == '0)) ||
                      ((state == GAP) && (idx_nxt == IDX_W'(gap_q))));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the wide latched payload and shifter are reset as well, so nothing from a
    // previous frame survives a reset; all state uses non-blocking assignments.
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      pay_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      rpt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      err_len <= 1'b0;
      dl_out  <= 1'b0;
      dl_en   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      err_len <= 1'b0;
      if (state == IDLE) begin
        // A start coinciding with abort is dropped silently.
        if (start && !abort) begin
          if (len_ok) begin
            pay_q   <= payload;
            len_q   <= payload_len;
            div_q   <= clk_div;
            gap_q   <= gap_bits;
            rpt_q   <= repeat_cnt;
            timer   <= '0;
            bit_idx <= '0;
            state   <= PREAMBLE;
            busy    <= 1'b1;
            dl_en   <= 1'b1;
            dl_out  <= 1'b1;
          end else begin
            err_len <= 1'b1;
          end
        end
      end else if (abort) begin
        state   <= IDLE;
        timer   <= '0;
        bit_idx <= '0;
        busy    <= 1'b0;
        dl_en   <= 1'b0;
        dl_out  <= 1'b0;
        aborted <= 1'b1;
      end else if (!bit_end) begin
        timer <= timer + DIV_WIDTH'(1);
      end else if (frame_end) begin
        timer   <= '0;
        bit_idx <= '0;
        if (rpt_q != '0) begin
          rpt_q  <= rpt_q - RPT_WIDTH'(1);
          state  <= PREAMBLE;
          dl_en  <= 1'b1;
          dl_out <= 1'b1;
        end else begin
          state  <= IDLE;
          busy   <= 1'b0;
          dl_en  <= 1'b0;
          dl_out <= 1'b0;
          done   <= 1'b1;
        end
      end else begin
        timer   <= '0;
        bit_idx <= idx_nxt;
        if (state == PREAMBLE) begin
          if (idx_nxt == IDX_W'(PREAMBLE_BITS)) begin
            state   <= PAYLOAD;
            bit_idx <= '0;
            dl_out  <= pay_q[0];
            sh_q    <= pay_q >> 1;
          end else begin
            dl_out <= ~idx_nxt[0];
          end
        end else if (state == PAYLOAD) begin
          if (idx_nxt == IDX_W'(len_q)) begin
            // Last payload bit done and a gap follows (no-gap case is frame_end).
            state   <= GAP;
            bit_idx <= '0;
            dl_en   <= 1'b0;
            dl_out  <= 1'b0;
          end else begin
            dl_out <= sh_q[0];
            sh_q   <= sh_q >> 1;
          end
        end
      end
    end
  end

endmodule
